mem_stage: RTL

Memory-access stage sitting directly downstream of the 16-bit ALU in the WISC pipeline. It registers each ALU result and issues LW/SW accesses to data memory over a req/ack handshake. It stalls the execute stage while an access is outstanding, then hands a single writeback beat to the register-file stage. Non-memory results pass through with one cycle of latency. A HLT is retired and the stage then halts.

---
 rtl/wisc_pkg.sv | 35 +++
 rtl/mem_stage_if.sv | 18 +
 rtl/mem_wait_timer.sv | 27 ++
 rtl/mem_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// wisc_pkg -- shared WISC definitions: word/register widths, the 4-bit opcode
// map (same encoding the ALU decodes), and the memory-stage state type.
package wisc_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 4;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALT   = 2'd2
    } mem_state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory request/acknowledge channel.
//   req   : access outstanding          we    : 1 = store, 0 = load
//   addr  : word address (bit 0 = 0)    wdata : store data
//   rdata : load data, valid with ack   ack   : memory completes the access
// master = memory stage, slave = data memory.
interface mem_stage_if;
    import wisc_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input  rdata, ack);
    modport slave  (input  req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer -- counts cycles spent waiting for a memory acknowledge.
//   clr : hold the count at zero      en : count this cycle
//   tc  : this is the LIMIT-th waiting cycle
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_wait_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,     // asynchronous, active-low
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= cnt + CNT_W'(1);
    end

    // cnt holds the number of cycles already waited, so the LIMIT-th
    // waiting cycle is the one where it reads LIMIT-1.
    assign tc = (cnt == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/mem_stage.sv
// mem_stage -- WISC memory-access stage behind the ALU.
// Registers each ALU result, performs LW/SW over the dmem req/ack channel while
// stalling execute, and emits one writeback beat per retired op. HLT retires
// and parks the stage in HALT until reset.
//   clk, rst        : clock; asynchronous active-low reset
//   ex_*            : operation from execute; accepted when ex_valid & !mem_stall
//   mem_stall       : execute must hold (pure state decode)
//   dmem            : data-memory channel (mem_stage_if.master)
//   wb_*            : one-cycle writeback beat to the register file
//   halted, mem_err : sticky status
// Optional: define MEM_TIMEOUT_EN to abandon an access after TIMEOUT_CYCLES
// unacknowledged cycles (mem_err set, wb beat without register write).
module mem_stage
    import wisc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [3:0]            ex_opcode,
    input  logic [WORD_W-1:0]     ex_alu_out,
    input  logic [WORD_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  ex_wr_en,
    output logic                  mem_stall,
    mem_stage_if.master           dmem,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic [WORD_W-1:0]     wb_data,
    output logic                  wb_wr_en,
    output logic                  halted,
    output logic                  mem_err
);
    mem_state_t state, state_nxt;

    logic [WORD_W-1:0]     addr_q, wdata_q;
    logic [REG_ADDR_W-1:0] dst_q;
    logic                  we_q;
    logic                  timeout;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_stall = (state != IDLE);
        dmem.req  = (state == ACCESS);
        unique case (state)
            IDLE: if (ex_valid) begin
                if (is_mem_op(ex_opcode))     state_nxt = ACCESS;
                else if (ex_opcode == OP_HLT) state_nxt = HALT;
            end
            ACCESS: if (dmem.ack || timeout) state_nxt = IDLE;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            dst_q    <= '0;
            we_q     <= 1'b0;
            wb_valid <= 1'b0;
            wb_dst   <= '0;
            wb_data  <= '0;
            wb_wr_en <= 1'b0;
            halted   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            unique case (state)
                IDLE: if (ex_valid) begin
                    if (is_mem_op(ex_opcode)) begin
                        addr_q  <= ex_alu_out;
                        wdata_q <= ex_store_data;
                        dst_q   <= ex_dst;
                        we_q    <= (ex_opcode == OP_SW);
                    end else begin
                        // pass-through and HLT both retire here next cycle
                        wb_valid <= 1'b1;
                        wb_dst   <= ex_dst;
                        wb_data  <= ex_alu_out;
                        wb_wr_en <= ex_wr_en && (ex_opcode != OP_HLT);
                        if (ex_opcode == OP_HLT) halted <= 1'b1;
                    end
                end
                ACCESS: if (dmem.ack) begin
                    // ack beats a coincident timeout
                    wb_valid <= 1'b1;
                    wb_dst   <= dst_q;
                    wb_wr_en <= !we_q;
                    if (!we_q) wb_data <= dmem.rdata;
                end else if (timeout) begin
                    wb_valid <= 1'b1;
                    wb_dst   <= dst_q;
                    wb_wr_en <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dmem.addr  = addr_q & ~WORD_W'(1);
    assign dmem.we    = we_q;
    assign dmem.wdata = wdata_q;

    // ---------------- optional access timeout ----------------
`ifdef MEM_TIMEOUT_EN
    logic tc, mem_err_q;

    mem_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
        .clk (clk),
        .rst (rst),
        .clr (state != ACCESS),      // zero on every entry into ACCESS
        .en  ((state == ACCESS) && !dmem.ack),
        .tc  (tc)
    );

    assign timeout = (state == ACCESS) && tc && !dmem.ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         mem_err_q <= 1'b0;
        else if (timeout) mem_err_q <= 1'b1;
    end
    assign mem_err = mem_err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif
endmodule
